// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver (and a future transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int CLKS_PER_TICK_DEF = 325;
  localparam int OVERSAMPLE_DEF    = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every CLKS_PER_TICK clocks, held at zero by clear_i.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || cnt_q == TERM) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign tick_o = !clear_i && (cnt_q == TERM);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-point majority vote and held valid/ack output.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF,
  parameter int OVERSAMPLE    = OVERSAMPLE_DEF,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [2:0]           dbg_state_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_os: illegal parameter combination");
  end

  rx_state_e            state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [SW-1:0]        s_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] sr_q;
  logic                 v0_q, v1_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q;
  logic                 tick, vote_d, at_vote, at_end, complete, tick_clear;

  assign vote_d     = maj3(v0_q, v1_q, rx_s_q);
  assign at_vote    = tick && (s_q == S_V2);
  assign at_end     = tick && (s_q == S_LAST);
  assign complete   = (state_q == STOP) && at_vote;
  assign tick_clear = (state_q == IDLE) || (state_q == WAIT_HIGH);

  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .clear_i(tick_clear),
    .tick_o (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_err_q, perr_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;

      if (tick) begin
        s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
        if (s_q == S_V0) v0_q <= rx_s_q;
        if (s_q == S_V1) v1_q <= rx_s_q;
      end

      case (state_q)
        IDLE: begin
          s_q   <= '0;
          bit_q <= '0;
`ifdef UART_RX_PARITY_EN
          par_err_q <= 1'b0;
`endif
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          if (at_vote && vote_d) state_q <= IDLE;
          else if (at_end) state_q <= DATA;
        end
        DATA: begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          if (at_vote) sr_q <= {vote_d, sr_q[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_vote) par_err_q <= vote_d != ((^sr_q) ^ 1'(PARITY_ODD));
          if (at_end) state_q <= STOP;
        end
`endif
        STOP: begin
          // Complete at mid stop bit so a following start edge is never missed.
          if (at_vote) state_q <= vote_d ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (complete) begin
        data_q  <= sr_q;
        ferr_q  <= ~vote_d;
        valid_q <= 1'b1;
        if (valid_q) ovr_q <= !data_ack;
`ifdef UART_RX_PARITY_EN
        perr_q  <= par_err_q;
`endif
      end else if (data_ack && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;
  assign dbg_state_o = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at a scaled bit time (4 clk/tick x 16 = 64 clk per bit).
module tb_uart_rx_os;

  localparam int CPT = 4;
  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int BIT = CPT * OS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic data_ack = 1'b0;
  logic [DB-1:0] data;
  logic data_valid, frame_err, parity_err, overrun;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLKS_PER_TICK(CPT),
    .OVERSAMPLE   (OS),
    .DATA_BITS    (DB),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .dbg_state_o(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int rises = 0;
  int rise_cyc = 0;
  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (data_valid === 1'b1 && dv_prev !== 1'b1) begin
      rises++;
      rise_cyc = cyc;
    end
    dv_prev = data_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {frame_err, parity_err, data}
  int errors = 0;
  int checks = 0;
  logic [DB+1:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input logic exp_ovr);
    bit ok;
    logic [DB+1:0] e;
    wait_valid(2 * BIT, ok);
    check({name, "_valid_seen"}, 16'(ok), 16'd1);
    if (exp_q.size() == 0) begin
      check({name, "_queue_nonempty"}, 16'(exp_q.size()), 16'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, 16'(data), 16'(e[DB-1:0]));
      check({name, "_frame_err"}, 16'(frame_err), 16'(e[DB+1]));
      check({name, "_parity_err"}, 16'(parity_err), 16'(e[DB]));
      check({name, "_overrun"}, 16'(overrun), 16'(exp_ovr));
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic       par_flip;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int r0;
    int lat;

    vecs[0] = '{tx: 8'h00, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[1] = '{tx: 8'hFF, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[2] = '{tx: 8'h3C, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{tx: 8'h96, stop: 1'b0, par_flip: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0};
    vecs[4] = '{tx: 8'hA5, stop: 1'b1, par_flip: 1'b1, exp_ferr: 1'b0, exp_perr: PAR_EN};
    vecs[5] = '{tx: 8'hA5, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[6] = '{tx: 8'h01, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data", 16'(data), 16'h0);
    check("rst_valid", 16'(data_valid), 16'h0);
    check("rst_frame_err", 16'(frame_err), 16'h0);
    check("rst_parity_err", 16'(parity_err), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    check("rst_state", 16'(dbg_state), 16'h0);
    rst = 1'b1;
    idle(2 * BIT);

    // 0xAB clean, with start-edge-to-valid latency window of 9.5..9.75 bit periods
    exp_q.push_back({1'b0, 1'b0, 8'hAB});
    r0 = cyc;
    send_frame(8'hAB, 1'b1, ^8'hAB);
    check_frame("ab", 1'b0);
    lat = rise_cyc - r0;
    check("ab_latency_in_window", 16'((lat >= (BIT * 19) / 2) && (lat <= (BIT * 39) / 4)), 16'd1);
    ack();
    check("ab_valid_after_ack", 16'(data_valid), 16'h0);
    idle(BIT);

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].tx});
      send_frame(vecs[i].tx, vecs[i].stop, (^vecs[i].tx) ^ vecs[i].par_flip);
      idle(BIT / 2);
      check_frame($sformatf("vec%0d", i), 1'b0);
      ack();
      check($sformatf("vec%0d_valid_after_ack", i), 16'(data_valid), 16'h0);
      idle(BIT);
    end

    // false start: 3-tick low glitch
    r0 = rises;
    rx = 1'b0;
    repeat (3 * CPT) @(negedge clk);
    idle(3 * BIT);
    check("glitch_no_valid", 16'(rises - r0), 16'h0);
    check("glitch_state_idle", 16'(dbg_state), 16'h0);

    // framing error followed by a 20-bit break
    r0 = rises;
    exp_q.push_back({1'b1, 1'b0, 8'h55});
    send_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    check("break_state_wait_high", 16'(dbg_state), 16'd5);
    idle(2 * BIT);
    check("break_one_valid", 16'(rises - r0), 16'd1);
    check_frame("brk55", 1'b0);
    ack();
    exp_q.push_back({1'b0, 1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, ^8'h3C);
    check_frame("after_break", 1'b0);
    ack();
    idle(BIT);

    // back-to-back frames without ack -> overrun, newest wins
    exp_q.push_back({1'b0, 1'b0, 8'h12});
    send_frame(8'h12, 1'b1, ^8'h12);
    check_frame("ovr_first", 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h34});
    send_frame(8'h34, 1'b1, ^8'h34);
    check_frame("ovr_second", 1'b1);
    ack();
    check("ovr_valid_cleared", 16'(data_valid), 16'h0);
    check("ovr_overrun_cleared", 16'(overrun), 16'h0);
    ack();
    check("ack_when_idle_ignored", 16'(data_valid), 16'h0);
    idle(BIT);

    // reset in the middle of 0x81 while a previous frame is still held
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, ^8'h5A);
    check_frame("held5a", 1'b0);
    r0 = rises;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    #2;
    rst = 1'b0;
    rx = 1'b1;
    #1;
    check("midrst_valid", 16'(data_valid), 16'h0);
    check("midrst_data", 16'(data), 16'h0);
    check("midrst_overrun", 16'(overrun), 16'h0);
    check("midrst_frame_err", 16'(frame_err), 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(3 * BIT);
    check("midrst_no_valid", 16'(rises - r0), 16'h0);
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    send_frame(8'hFF, 1'b1, ^8'hFF);
    check_frame("after_rst_ff", 1'b0);
    ack();
    idle(BIT);

    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
